// File: rtl/led_pattern_sequencer_if.sv
// ----------------------------------------------------------------------------
// led_pattern_sequencer_if
//   Control and status bundle for the LED pattern sequencer.
//
//   START  master->slave  one-cycle request to begin a sequence
//   STOP   master->slave  abort the running sequence
//   MODE   master->slave  pattern select: 0 none, 1 blink, 2 chase, 3 fill
//   LED    slave->master  N_LEDS-wide LED drive
//   BUSY   slave->master  high while a pattern is running
//   DONE   slave->master  one-cycle pulse when all passes complete
// ----------------------------------------------------------------------------
interface led_pattern_sequencer_if #(
    parameter int N_LEDS = 16
) ();
    logic              START;
    logic              STOP;
    logic [1:0]        MODE;
    logic [N_LEDS-1:0] LED;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START, STOP, MODE,
        input  LED, BUSY, DONE
    );

    modport slave (
        input  START, STOP, MODE,
        output LED, BUSY, DONE
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// led_pattern_sequencer
//   Animates an LED bank (blink / chase / bar-fill) for a fixed number of
//   passes per START, then pulses DONE. All state lives in the CLK domain;
//   the divided slow clocks are only sampled as rising-edge tick sources.
//
//   CLK        system clock (100 MHz)
//   RST_N      asynchronous active-low reset
//   SLOWCLK_A  10 Hz square wave, paces blink and fill
//   SLOWCLK_B  6 Hz square wave, paces chase
//   bus        START/STOP/MODE in, LED/BUSY/DONE out (slave modport)
// ----------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int N_LEDS = 16,   // minimum 2
    parameter int PASSES = 3     // 0 = run until STOP
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   SLOWCLK_A,
    input  logic                   SLOWCLK_B,
    led_pattern_sequencer_if.slave bus
);
    localparam int CNT_W = (PASSES > 0) ? $clog2(PASSES + 1) : 1;

    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_FILL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         mode_r;
    logic [N_LEDS-1:0]  led_r, led_step;
    logic [CNT_W-1:0]   pass_cnt, cnt_inc;
    logic [1:0]         sync_a, sync_b;
    logic               hist_a, hist_b;
    logic               tick_a, tick_b, tick_sel;
    logic               pass_done, launch, advance, last_pass, cnt_sat;
    logic [N_LEDS-1:0]  led_o;
    logic               busy_o, done_o;

    // Slow-clock synchronisers run in every state, so the edge history is
    // already valid when RUN is entered and no spurious tick can appear.
    // NOTE: only control/state flops take the async reset here; a plain data
    // array would not need one, but these feed the FSM directly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_a <= '0;
            sync_b <= '0;
            hist_a <= 1'b0;
            hist_b <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop in the chain
            // sample the old value of its predecessor on the same edge.
            sync_a <= {sync_a[0], SLOWCLK_A};
            sync_b <= {sync_b[0], SLOWCLK_B};
            hist_a <= sync_a[1];
            hist_b <= sync_b[1];
        end
    end

    // One-cycle pulse per slow-clock rising edge.
    assign tick_a = sync_a[1] & ~hist_a;
    assign tick_b = sync_b[1] & ~hist_b;

    // Next pattern value, the tick that paces it, and whether this step
    // closes a pass. The step value is already the wrap pattern.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        led_step  = led_r;
        pass_done = 1'b0;
        tick_sel  = 1'b0;
        unique case (mode_r)
            MODE_BLINK: begin
                tick_sel  = tick_a;
                led_step  = ~led_r;
                pass_done = &led_r;
            end
            MODE_CHASE: begin
                tick_sel  = tick_b;
                led_step  = {led_r[N_LEDS-2:0], led_r[N_LEDS-1]};
                pass_done = led_r[N_LEDS-1];
            end
            MODE_FILL: begin
                tick_sel  = tick_a;
                led_step  = (&led_r) ? '0 : {led_r[N_LEDS-2:0], 1'b1};
                pass_done = &led_r;
            end
            default: ;
        endcase
    end

    assign launch    = (state == S_IDLE) && bus.START && !bus.STOP;
    assign advance   = (state == S_RUN) && !bus.STOP && tick_sel;
    assign cnt_inc   = pass_cnt + CNT_W'(1);
    assign cnt_sat   = (PASSES == 0) && (&pass_cnt);
    assign last_pass = (PASSES != 0) && advance && pass_done
                       && (cnt_inc == CNT_W'(PASSES));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; STOP outranks both START and a same-cycle tick.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (launch) state_nxt = (bus.MODE == MODE_NONE) ? S_FIN : S_RUN;
            S_RUN: begin
                if (bus.STOP)     state_nxt = S_IDLE;
                else if (last_pass) state_nxt = S_FIN;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pattern datapath. led_r is only visible in RUN, so it is left as-is
    // on STOP or completion instead of being cleared.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_r   <= MODE_NONE;
            led_r    <= '0;
            pass_cnt <= '0;
        end else if (launch) begin
            mode_r   <= bus.MODE;
            pass_cnt <= '0;
            unique case (bus.MODE)
                MODE_BLINK: led_r <= '1;
                MODE_CHASE: led_r <= N_LEDS'(1);
                default:    led_r <= '0;
            endcase
        end else if (advance) begin
            led_r <= led_step;
            if (pass_done && !cnt_sat) pass_cnt <= cnt_inc;
        end
    end

    // Outputs depend on state only, so reset blanks them immediately.
    always_comb begin
        led_o  = '0;
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state)
            S_RUN: begin
                led_o  = led_r;
                busy_o = 1'b1;
            end
            S_FIN:   done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.LED  = led_o;
    assign bus.BUSY = busy_o;
    assign bus.DONE = done_o;
endmodule
